// File: rtl/bk_uart_frame_pkg.sv
// Shared constants and state encodings for the BK UART frame responder and its byte sender.
package bk_uart_frame_pkg;

   localparam logic [7:0] SOF_REQ = 8'hA5;
   localparam logic [7:0] SOF_RSP = 8'h5A;
   localparam logic [7:0] NAK_LEN = 8'h00;
   localparam logic [7:0] NAK_CHK = 8'h00;

   typedef enum logic [4:0] {
      HUNT    = 5'b00001,
      GET_LEN = 5'b00010,
      GET_PAY = 5'b00100,
      GET_CHK = 5'b01000,
      REPLY   = 5'b10000
   } rx_state_t;

   typedef enum logic [4:0] {
      SND_IDLE    = 5'b00001,
      SND_SEND    = 5'b00010,
      SND_WAIT_HI = 5'b00100,
      SND_WAIT_LO = 5'b01000,
      SND_GAP     = 5'b10000
   } snd_state_t;

endpackage

// File: rtl/bk_uart_frame_responder_sender.sv
// One-byte BKP01 master handshake: pulse ready, wait for busy to rise and fall, then one idle cycle.
module bk_byte_sender
   import bk_uart_frame_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       done,
   output logic [7:0] BKP01_data_o,
   output logic       BKP01_ready_o,
   input  logic       BKP01_busy_i
);

   snd_state_t state_q, state_d;
   logic [7:0] data_q;

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         SND_IDLE:    if (start) state_d = SND_SEND;
         SND_SEND:    state_d = SND_WAIT_HI;
         SND_WAIT_HI: if (BKP01_busy_i) state_d = SND_WAIT_LO;
         SND_WAIT_LO: if (!BKP01_busy_i) state_d = SND_GAP;
         // GAP is the idle cycle; a start here goes straight into the next SEND
         SND_GAP: begin
            done    = 1'b1;
            state_d = start ? SND_SEND : SND_IDLE;
         end
         default:     state_d = SND_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SND_IDLE;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         if (start && (state_q inside {SND_IDLE, SND_GAP})) data_q <= tx_byte;
      end
   end

   assign BKP01_ready_o = (state_q == SND_SEND);
   assign BKP01_data_o  = data_q;

endmodule

// File: rtl/bk_uart_frame_responder.sv
// Parses SOF/LEN/payload/XOR frames from the UART receive port and answers with an echo or NAK reply.
module bk_uart_frame_responder
   import bk_uart_frame_pkg::*;
#(
   parameter int MAX_LEN        = 16,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] BKP02_data_i,
   input  logic       BKP02_ready_i,
   output logic       BKP02_busy_o,
   output logic [7:0] BKP01_data_o,
   output logic       BKP01_ready_o,
   input  logic       BKP01_busy_i,
   output logic       frame_ok_o,
   output logic       frame_err_o,
   output logic [7:0] drop_cnt_o
);

   localparam int IDX_W  = $clog2(MAX_LEN + 1);
   localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   rx_state_t        state_q, state_d;
   logic [7:0]       len_q, xor_q, chk_q, drop_q;
   logic [IDX_W-1:0] idx_q;
   logic [8:0]       ridx_q, rsp_total;
   logic [TMO_W-1:0] gap_q;
   logic             nak_q, ok_q, err_q, ok_d, err_d;
   logic             waiting, tmo, take;
   logic             snd_start, snd_done;
   logic [7:0]       snd_byte, rsp_byte;
   logic [BUF_AW-1:0] rd_idx;
   logic [7:0]       pay_buf [MAX_LEN];

   assign waiting   = state_q inside {GET_LEN, GET_PAY, GET_CHK};
   assign tmo       = waiting && (gap_q == TMO_W'(TIMEOUT_CYCLES));
   assign take      = BKP02_ready_i && !tmo && (state_q != REPLY);
   assign rsp_total = nak_q ? 9'd3 : ({1'b0, len_q} + 9'd3);
   assign rd_idx    = BUF_AW'(ridx_q - 9'd2);

   // Reply byte k (k >= 1); byte 0 is the SOF issued on entry to REPLY
   always_comb begin
      rsp_byte = chk_q;
      if (nak_q)
         rsp_byte = (ridx_q == 9'd1) ? NAK_LEN : NAK_CHK;
      else if (ridx_q == 9'd1)
         rsp_byte = len_q;
      else if (ridx_q <= ({1'b0, len_q} + 9'd1))
         rsp_byte = pay_buf[rd_idx];
   end

   always_comb begin
      state_d   = state_q;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      snd_start = 1'b0;
      snd_byte  = rsp_byte;
      unique case (state_q)
         HUNT: if (take && (BKP02_data_i == SOF_REQ)) state_d = GET_LEN;
         GET_LEN: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end else if (take) begin
               if ((BKP02_data_i == 8'h00) || (BKP02_data_i > 8'(MAX_LEN))) begin
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  state_d = GET_PAY;
               end
            end
         end
         GET_PAY: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end else if (take && ((8'(idx_q) + 8'd1) == len_q)) begin
               state_d = GET_CHK;
            end
         end
         GET_CHK: begin
            if (tmo) begin
               err_d   = 1'b1;
               state_d = HUNT;
            end else if (take) begin
               state_d   = REPLY;
               snd_start = 1'b1;
               snd_byte  = SOF_RSP;
               if (BKP02_data_i == xor_q) ok_d = 1'b1;
               else                       err_d = 1'b1;
            end
         end
         REPLY: begin
            if (snd_done) begin
               if (ridx_q == rsp_total) state_d = HUNT;
               else                     snd_start = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= 8'h00;
         len_q   <= 8'h00;
         xor_q   <= 8'h00;
         chk_q   <= 8'h00;
         idx_q   <= '0;
         ridx_q  <= 9'd0;
         nak_q   <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         if (BKP02_ready_i && (state_q == REPLY) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
         if (take || !waiting) gap_q <= '0;
         else                  gap_q <= gap_q + TMO_W'(1);
         if (take) begin
            case (state_q)
               GET_LEN: begin
                  len_q <= BKP02_data_i;
                  xor_q <= BKP02_data_i;
                  idx_q <= '0;
               end
               GET_PAY: begin
                  xor_q <= xor_q ^ BKP02_data_i;
                  idx_q <= idx_q + IDX_W'(1);
               end
               GET_CHK: begin
                  chk_q  <= BKP02_data_i;
                  nak_q  <= (BKP02_data_i != xor_q);
                  ridx_q <= 9'd1;
               end
               default: ;
            endcase
         end
         if ((state_q == REPLY) && snd_start) ridx_q <= ridx_q + 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == GET_PAY) && take) pay_buf[idx_q[BUF_AW-1:0]] <= BKP02_data_i;
   end

   bk_byte_sender u_sender (
      .clk           (clk),
      .rst           (rst),
      .start         (snd_start),
      .tx_byte       (snd_byte),
      .done          (snd_done),
      .BKP01_data_o  (BKP01_data_o),
      .BKP01_ready_o (BKP01_ready_o),
      .BKP01_busy_i  (BKP01_busy_i)
   );

   assign BKP02_busy_o = (state_q == REPLY);
   assign frame_ok_o   = ok_q;
   assign frame_err_o  = err_q;
   assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_bk_uart_frame_responder.sv
// Bench for bk_uart_frame_responder: vector table, hand-written corner sequences, random frames vs a frame-level model.
module tb_bk_uart_frame_responder;

   localparam int MAXL = 16;
   localparam int TMO  = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] BKP02_data_i = 8'h00;
   logic       BKP02_ready_i = 1'b0;
   logic       BKP02_busy_o;
   logic [7:0] BKP01_data_o;
   logic       BKP01_ready_o;
   logic       BKP01_busy_i = 1'b0;
   logic       frame_ok_o, frame_err_o;
   logic [7:0] drop_cnt_o;

   bk_uart_frame_responder #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .BKP02_data_i  (BKP02_data_i),
      .BKP02_ready_i (BKP02_ready_i),
      .BKP02_busy_o  (BKP02_busy_o),
      .BKP01_data_o  (BKP01_data_o),
      .BKP01_ready_o (BKP01_ready_o),
      .BKP01_busy_i  (BKP01_busy_i),
      .frame_ok_o    (frame_ok_o),
      .frame_err_o   (frame_err_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0, ok_cnt = 0, err_cnt = 0, err_cyc = 0, last_acc = 0;
   int hi_dly = 1, busy_len = 2, hcnt = 0, bcnt = 0;
   bit pend = 0, ubusy = 0, prev_rdy = 0;
   logic [7:0] hold = 8'h00;
   logic [7:0] rx_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // UART model: busy rises hi_dly cycles after each ready pulse, stays up busy_len cycles
   always @(negedge clk) begin
      if (rst) begin
         pend = 0; ubusy = 0; prev_rdy = 0; BKP01_busy_i = 1'b0;
      end else begin
         if (BKP01_ready_o) begin
            chk("ready_gap", {29'd0, prev_rdy, ubusy, pend}, 32'd0);
            rx_q.push_back(BKP01_data_o);
            hold = BKP01_data_o;
            pend = 1;
            hcnt = hi_dly;
         end else if (pend) begin
            hcnt--;
            if (hcnt == 0) begin
               pend = 0; ubusy = 1; bcnt = busy_len; BKP01_busy_i = 1'b1;
            end
         end else if (ubusy) begin
            chk("data_hold", {24'd0, BKP01_data_o}, {24'd0, hold});
            bcnt--;
            if (bcnt == 0) begin
               ubusy = 0; BKP01_busy_i = 1'b0;
            end
         end
         prev_rdy = BKP01_ready_o;
      end
   end

   always @(negedge clk) begin
      if (frame_ok_o) ok_cnt++;
      if (frame_err_o) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (frame_ok_o || frame_err_o) chk("ok_err_excl", {31'd0, frame_ok_o & frame_err_o}, 32'd0);
   end

   task automatic send_byte(input logic [7:0] b);
      BKP02_data_i  = b;
      BKP02_ready_i = 1'b1;
      last_acc      = cyc;
      @(posedge clk); #1;
      BKP02_ready_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk);
      while ((BKP02_busy_o || ubusy || pend) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("reply_bound", 32'(n >= 5000), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_q(input string nm, input logic [7:0] eq[$]);
      chk({nm, "_n"}, 32'(rx_q.size()), 32'(eq.size()));
      for (int i = 0; i < eq.size() && i < rx_q.size(); i++)
         chk($sformatf("%s_b%0d", nm, i), {24'd0, rx_q[i]}, {24'd0, eq[i]});
   endtask

   task automatic check_outputs_zero(input string nm);
      chk({nm, "_ready"}, {31'd0, BKP01_ready_o}, 32'd0);
      chk({nm, "_data"},  {24'd0, BKP01_data_o}, 32'd0);
      chk({nm, "_busy"},  {31'd0, BKP02_busy_o}, 32'd0);
      chk({nm, "_ok"},    {31'd0, frame_ok_o}, 32'd0);
      chk({nm, "_err"},   {31'd0, frame_err_o}, 32'd0);
      chk({nm, "_drop"},  {24'd0, drop_cnt_o}, 32'd0);
   endtask

   typedef struct {
      int           ni;
      logic [159:0] ib;
      int           no;
      logic [159:0] ob;
      int           eok;
      int           eerr;
   } vec_t;

   vec_t vec[10];

   task automatic run_frame(input logic [7:0] sq[$], input logic [7:0] eq[$], input int eok,
                            input int eerr, input string nm);
      int ok0 = ok_cnt, err0 = err_cnt;
      rx_q.delete();
      foreach (sq[i]) send_byte(sq[i]);
      wait_idle();
      check_q(nm, eq);
      chk({nm, "_ok"},  32'(ok_cnt - ok0), 32'(eok));
      chk({nm, "_err"}, 32'(err_cnt - err0), 32'(eerr));
   endtask

   task automatic run_random(input int nfr);
      logic [7:0] sq[$], eq[$], pay[$];
      logic [7:0] len, x, b;
      int kind, ok0, err0;
      for (int f = 0; f < nfr; f++) begin
         sq.delete(); eq.delete(); pay.delete();
         kind     = $urandom_range(0, 3);
         hi_dly   = $urandom_range(1, 3);
         busy_len = $urandom_range(1, 4);
         for (int i = 0; i < $urandom_range(0, 2); i++) begin
            b = 8'($urandom_range(0, 254));
            if (b >= 8'hA5) b++;
            sq.push_back(b);
         end
         if (kind == 3) len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
         else           len = 8'($urandom_range(1, MAXL));
         sq.push_back(8'hA5);
         sq.push_back(len);
         if (kind != 3) begin
            x = len;
            for (int i = 0; i < len; i++) begin
               pay.push_back(8'($urandom_range(0, 255)));
               x ^= pay[i];
            end
            if (kind == 2) x ^= 8'($urandom_range(1, 255));
            foreach (pay[i]) sq.push_back(pay[i]);
            sq.push_back(x);
            if (kind == 2) eq = '{8'h5A, 8'h00, 8'h00};
            else begin
               eq.push_back(8'h5A); eq.push_back(len);
               foreach (pay[i]) eq.push_back(pay[i]);
               eq.push_back(x);
            end
         end
         ok0 = ok_cnt; err0 = err_cnt;
         rx_q.delete();
         foreach (sq[i]) begin
            send_byte(sq[i]);
            idle($urandom_range(0, 3));
         end
         wait_idle();
         check_q($sformatf("rnd%0d", f), eq);
         chk($sformatf("rnd%0d_ok", f),  32'(ok_cnt - ok0), (kind <= 1) ? 32'd1 : 32'd0);
         chk($sformatf("rnd%0d_err", f), 32'(err_cnt - err0), (kind >= 2) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sq[$], eq[$];
      int c0, err0;

      repeat (3) @(posedge clk); #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      idle(2);

      vec[0] = '{5, 160'({8'hA5, 8'h02, 8'h11, 8'h22, 8'h31}), 5, 160'({8'h5A, 8'h02, 8'h11, 8'h22, 8'h31}), 1, 0};
      vec[1] = '{5, 160'({8'hA5, 8'h02, 8'h11, 8'h22, 8'h33}), 3, 160'({8'h5A, 8'h00, 8'h00}), 0, 1};
      vec[2] = '{4, 160'({8'hA5, 8'h01, 8'h44, 8'h00}), 3, 160'({8'h5A, 8'h00, 8'h00}), 0, 1};
      vec[3] = '{6, 160'({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}), 4, 160'({8'h5A, 8'h01, 8'h7E, 8'h7F}), 1, 0};
      vec[4] = '{2, 160'({8'hA5, 8'h11}), 0, 160'd0, 0, 1};
      vec[5] = vec[0];
      vec[6] = '{2, 160'({8'hA5, 8'h00}), 0, 160'd0, 0, 1};
      vec[7] = '{19, 160'({8'hA5, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h10}),
                 19, 160'({8'h5A, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h10}), 1, 0};
      vec[8] = '{4, 160'({8'hA5, 8'h01, 8'h00, 8'h01}), 4, 160'({8'h5A, 8'h01, 8'h00, 8'h01}), 1, 0};
      vec[9] = '{2, 160'({8'hA5, 8'hFF}), 0, 160'd0, 0, 1};

      for (int v = 0; v < 10; v++) begin
         sq.delete(); eq.delete();
         for (int i = 0; i < vec[v].ni; i++) sq.push_back(vec[v].ib[8*(vec[v].ni-1-i) +: 8]);
         for (int i = 0; i < vec[v].no; i++) eq.push_back(vec[v].ob[8*(vec[v].no-1-i) +: 8]);
         run_frame(sq, eq, vec[v].eok, vec[v].eerr, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_drop", v), {24'd0, drop_cnt_o}, 32'd0);
      end

      // Timeout: error pulse lands exactly TMO idle cycles after the last byte
      rx_q.delete();
      err0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      c0 = last_acc;
      idle(TMO + 5);
      chk("tmo_err", 32'(err_cnt - err0), 32'd1);
      chk("tmo_cycle", 32'(err_cyc), 32'(c0 + TMO + 2));
      chk("tmo_no_tx", 32'(rx_q.size()), 32'd0);
      run_frame('{8'hA5, 8'h01, 8'h7E, 8'h7F}, '{8'h5A, 8'h01, 8'h7E, 8'h7F}, 1, 0, "tmo_after");

      // A byte landing in the timeout cycle is discarded, so what follows is ignored in HUNT
      rx_q.delete();
      err0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      c0 = last_acc;
      idle(TMO);
      send_byte(8'hA5);
      send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      wait_idle();
      chk("tmo_race_err", 32'(err_cnt - err0), 32'd1);
      chk("tmo_race_cycle", 32'(err_cyc), 32'(c0 + TMO + 2));
      chk("tmo_race_no_tx", 32'(rx_q.size()), 32'd0);

      // Bytes arriving during a reply are dropped and counted
      busy_len = 3;
      run_frame('{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'hA5, 8'h02, 8'h11},
                '{8'h5A, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40}, 1, 0, "drop");
      chk("drop_cnt3", {24'd0, drop_cnt_o}, 32'd3);

      // Reset in the middle of a reply
      rx_q.delete();
      sq = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
      foreach (sq[i]) send_byte(sq[i]);
      idle(6);
      chk("midreset_busy_before", {31'd0, BKP02_busy_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("midreset");
      rst = 1'b0;
      idle(3);
      busy_len = 2;
      run_frame('{8'hA5, 8'h01, 8'h7E, 8'h7F}, '{8'h5A, 8'h01, 8'h7E, 8'h7F}, 1, 0, "post_reset");

      // Drop counter saturation
      busy_len = 80;
      rx_q.delete();
      sq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      foreach (sq[i]) send_byte(sq[i]);
      for (int i = 0; i < 260; i++) send_byte(8'(i));
      wait_idle();
      check_q("sat", '{8'h5A, 8'h01, 8'h7E, 8'h7F});
      chk("drop_sat", {24'd0, drop_cnt_o}, 32'd255);

      run_random(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
